dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_if.sv | 30 +++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory controller.
//   SZ_*     : access-size encodings carried on req_size.
//   state_e  : controller FSM states (CLEAR sweeps memory to zero, READY serves requests).
//   size_misaligned() : size/lane legality check independent of the address range.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef enum logic [0:0] {
    CLEAR = ST_CLEAR,
    READY = ST_READY
  } state_e;

  // 1 when the size code is illegal or the lane is not naturally aligned for it.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if -- request/response bundle between a requester (master) and dmem_ctrl (slave).
// Handshake: a request transfers on a rising clock edge where req_valid && req_ready;
// the requester holds req_* stable while req_valid is high and not yet accepted.
// rsp_valid is a one-cycle pulse with no backpressure; rsp_rdata/rsp_err hold between pulses.
// clr_req asks for a zero-fill sweep and masks req_ready while high.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              clr_req;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output clr_req, req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  clr_req, req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align -- combinational byte-lane steering.
//   Store path: st_size/st_lane/st_wdata -> st_be (byte enables), st_data (sub-word replicated
//               across lanes so any enabled lane sees the right byte).
//   Load path : ld_size/ld_lane/ld_unsigned/ld_word -> ld_data (extracted and extended).
// Illegal sizes produce no enables and zero load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (st_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << st_lane;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = st_lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
    ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = 32'h0;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data = ld_word;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- DEPTH x 32-bit data memory with byte/half/word access and a zero-fill sweep.
//   clk, rst  : sole clock; asynchronous active-high reset (starts a full sweep).
//   bus       : dmem_if slave port (requests, responses, clr_req).
//   dbg_state : current FSM state for observation.
// Pipeline: accept edge N captures the request (stores write memory at N); edge N+1
// registers the response, so rsp_valid is high in the cycle after edge N+1.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output state_e dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic             p_valid_q, p_valid_d;
  logic             p_we_q, p_we_d;
  logic             p_err_q, p_err_d;
  logic             p_unsigned_q, p_unsigned_d;
  logic [1:0]       p_size_q, p_size_d;
  logic [1:0]       p_lane_q, p_lane_d;
  logic [IDX_W-1:0] p_idx_q, p_idx_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [31:0]      mem [DEPTH];

  logic             req_ready;
  logic             accept;
  logic             fault;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lane;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [31:0]      rd_word;
  logic [31:0]      ld_data;

  assign req_idx   = bus.req_addr[IDX_W+1:2];
  assign req_lane  = bus.req_addr[1:0];
  // Any set bit above the array's byte range makes the address out of bounds.
  assign fault     = (|bus.req_addr[ADDR_W-1:IDX_W+2]) || size_misaligned(bus.req_size, req_lane);
  assign req_ready = (state_q == READY) && !bus.clr_req;
  assign accept    = bus.req_valid && req_ready;
  assign rd_word   = mem[p_idx_q];

  dmem_lane_align u_align (
    .st_size    (bus.req_size),
    .st_lane    (req_lane),
    .st_wdata   (bus.req_wdata),
    .st_be      (st_be),
    .st_data    (st_data),
    .ld_size    (p_size_q),
    .ld_lane    (p_lane_q),
    .ld_unsigned(p_unsigned_q),
    .ld_word    (rd_word),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    p_valid_d    = accept;
    p_we_d       = p_we_q;
    p_err_d      = p_err_q;
    p_unsigned_d = p_unsigned_q;
    p_size_d     = p_size_q;
    p_lane_d     = p_lane_q;
    p_idx_d      = p_idx_q;
    if (accept) begin
      p_we_d       = bus.req_we;
      p_err_d      = fault;
      p_unsigned_d = bus.req_unsigned;
      p_size_d     = bus.req_size;
      p_lane_d     = req_lane;
      p_idx_d      = req_idx;
    end
  end

  // The load reads the array one edge after accept; a store accepted on that same edge
  // writes with non-blocking semantics, so the earlier load still sees the older data.
  always_comb begin
    rsp_valid_d = p_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (p_valid_q) begin
      rsp_err_d   = p_err_q;
      rsp_rdata_d = (p_err_q || p_we_q) ? 32'h0 : ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      p_valid_q    <= 1'b0;
      p_we_q       <= 1'b0;
      p_err_q      <= 1'b0;
      p_unsigned_q <= 1'b0;
      p_size_q     <= SZ_BYTE;
      p_lane_q     <= 2'b00;
      p_idx_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      p_valid_q    <= p_valid_d;
      p_we_q       <= p_we_d;
      p_err_q      <= p_err_d;
      p_unsigned_q <= p_unsigned_d;
      p_size_q     <= p_size_d;
      p_lane_q     <= p_lane_d;
      p_idx_q      <= p_idx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Array has no reset; it is zeroed only by the sweep. Accepts never happen in CLEAR,
  // so the sweep write and a store write are mutually exclusive.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_idx_q] <= 32'h0;
    end else if (accept && bus.req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[req_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule
